// File: rtl/screen_seq_if.sv
// Bundle between screen_sequencer and the OLED driver / screen generators.
// Carries buttons, frame/pixel timing, generator colours and the sequencer outputs.
interface screen_seq_if;
   logic        btn_c;
   logic        btn_l;
   logic        btn_r;
   logic        frame_begin;
   logic [12:0] pixel_index;
   logic [15:0] pix_home;
   logic [15:0] pix_ctrl;
   logic [15:0] pix_game;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] oled_data;
   logic [1:0]  screen;
   logic        blink_on;
   logic        game_start;

   modport master (
      output btn_c, btn_l, btn_r, frame_begin, pixel_index,
      output pix_home, pix_ctrl, pix_game,
      input  x, y, oled_data, screen, blink_on, game_start
   );

   modport slave (
      input  btn_c, btn_l, btn_r, frame_begin, pixel_index,
      input  pix_home, pix_ctrl, pix_game,
      output x, y, oled_data, screen, blink_on, game_start
   );
endinterface

// File: rtl/screen_sequencer.sv
// Menu screen FSM with frame-aligned switching, blink phase and 2-stage pixel mux.
// Ports: clk, rst_n, bus (screen_seq_if.slave). Option: SCREEN_SEQ_PAUSE_EN.
module screen_sequencer #(
   parameter int unsigned BLINK_DIV = 3125000
) (
   input  logic        clk,
   input  logic        rst_n,
   screen_seq_if.slave bus
);

   typedef enum logic [1:0] {
      HOME  = 2'd0,
      CTRL  = 2'd1,
      GAME  = 2'd2,
      PAUSE = 2'd3
   } screen_t;

   localparam logic [23:0] BLINK_LAST = 24'(BLINK_DIV - 1);

   screen_t     scr;
   screen_t     pend_scr;
   logic        pend;
   logic [23:0] blink_cnt;
   logic        blink_q;
   logic        start_q;
   logic [6:0]  x_q;
   logic [5:0]  y_q;
   logic        inv_q;
   logic [15:0] oled_q;

   logic        apply;
   screen_t     cur;
   logic        req_v;
   screen_t     req_scr;
   logic [12:0] quo;
   logic [12:0] rem;
   logic        inv;
   logic [15:0] pix_sel;

   assign apply = bus.frame_begin & pend;

   // A request arriving with frame_begin is decoded against the screen
   // that is about to become current, not the one being left.
   always_comb begin
      cur     = apply ? pend_scr : scr;
      req_v   = 1'b0;
      req_scr = cur;
      case (cur)
         HOME: begin
            if (bus.btn_c) begin
               req_v   = 1'b1;
               req_scr = GAME;
            end else if (bus.btn_r) begin
               req_v   = 1'b1;
               req_scr = CTRL;
            end
         end
         CTRL: begin
            if (bus.btn_l) begin
               req_v   = 1'b1;
               req_scr = HOME;
            end
         end
         GAME: begin
`ifdef SCREEN_SEQ_PAUSE_EN
            if (bus.btn_c) begin
               req_v   = 1'b1;
               req_scr = PAUSE;
            end
`endif
         end
         PAUSE: begin
`ifdef SCREEN_SEQ_PAUSE_EN
            if (bus.btn_c) begin
               req_v   = 1'b1;
               req_scr = GAME;
            end else if (bus.btn_l) begin
               req_v   = 1'b1;
               req_scr = HOME;
            end
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scr       <= HOME;
         pend_scr  <= HOME;
         pend      <= 1'b0;
         blink_cnt <= 24'd0;
         blink_q   <= 1'b1;
         start_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (apply) begin
            scr     <= pend_scr;
            pend    <= 1'b0;
            start_q <= (scr == HOME) && (pend_scr == GAME);
         end
         if ((!pend || apply) && req_v) begin
            pend     <= 1'b1;
            pend_scr <= req_scr;
         end
         if (apply) begin
            blink_cnt <= 24'd0;
            blink_q   <= 1'b1;
         end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= 24'd0;
            blink_q   <= ~blink_q;
         end else begin
            blink_cnt <= blink_cnt + 24'd1;
         end
      end
   end

   // Quotient >= 64 means index >= 6144; the remainder bits above 6 are
   // always zero and are folded in only so every bit is consumed.
   assign quo = bus.pixel_index / 13'd96;
   assign rem = bus.pixel_index % 13'd96;
   assign inv = (|quo[12:6]) | (|rem[12:7]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= 7'd0;
         y_q   <= 6'd0;
         inv_q <= 1'b0;
      end else begin
         x_q   <= inv ? 7'd0 : rem[6:0];
         y_q   <= inv ? 6'd0 : quo[5:0];
         inv_q <= inv;
      end
   end

   always_comb begin
      pix_sel = 16'h0000;
      case (scr)
         HOME: pix_sel = bus.pix_home;
         CTRL: pix_sel = bus.pix_ctrl;
         GAME: pix_sel = bus.pix_game;
`ifdef SCREEN_SEQ_PAUSE_EN
         PAUSE: pix_sel = {1'b0, bus.pix_game[15:12],
                           1'b0, bus.pix_game[10:6],
                           1'b0, bus.pix_game[4:1]};
`endif
         default: pix_sel = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oled_q <= 16'h0000;
      end else begin
         oled_q <= inv_q ? 16'h0000 : pix_sel;
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.oled_data  = oled_q;
   assign bus.screen     = scr;
   assign bus.blink_on   = blink_q;
   assign bus.game_start = start_q;

endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level menu controller for the 96x64 OLED game display. Decodes single-cycle button pulses into a screen state machine (home, controls, game, pause) and applies screen changes only at frame boundaries so no frame tears. Converts the display driver's linear pixel index to x/y for the combinational screen generators, then muxes and registers their colour outputs into the single `oled_data` stream. Also generates the blink phase consumed by the home-screen icon and arrow generators.

## Interface
- `BLINK_DIV`, default 3125000: clock cycles per blink half-period (0.5 s at 6.25 MHz); legal range 2 to 2^24-1.
- `clk`  in  1  pixel clock, same clock as the OLED driver.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_c`, `btn_l`, `btn_r`  in  1 each  debounced single-cycle button pulses.
- `frame_begin`  in  1  one-cycle pulse from the OLED driver at the start of each frame.
- `pixel_index`  in  13  linear pixel index from the driver, 0..6143.
- `pix_home`, `pix_ctrl`, `pix_game`  in  16 each  RGB565 colour from the screen generators for the current `x`/`y`.
- `x`  out  7  column 0..95.
- `y`  out  6  row 0..63.
- `oled_data`  out  16  RGB565 pixel to the driver.
- `screen`  out  2  current screen: 0 HOME, 1 CONTROLS, 2 GAME, 3 PAUSE.
- `blink_on`  out  1  blink phase; 1 means the icon is visible.
- `game_start`  out  1  one-cycle pulse on HOME→GAME entry.

## Operation
- Reset values: `screen`=HOME, pending request cleared, `blink_on`=1, blink counter=0, `x`=0, `y`=0, `oled_data`=0x0000, `game_start`=0.
- Transition requests:
  - HOME: `btn_c`→GAME; `btn_r`→CONTROLS.
  - CONTROLS: `btn_l`→HOME.
  - GAME: `btn_c`→PAUSE.
  - PAUSE: `btn_c`→GAME; `btn_l`→HOME.
  - Any button with no listed transition in the current screen is ignored.
- Simultaneous buttons in the same cycle: priority is `btn_c` > `btn_l` > `btn_r`.
- Request handling:
  - A valid request is latched as pending.
  - While a request is pending, later buttons are ignored.
  - The pending request is applied on `frame_begin`.
  - A button arriving in the same cycle as `frame_begin` is latched as a new request. It is not applied in that cycle, even if nothing is already pending.
- Blink:
  - The counter counts 0..`BLINK_DIV`-1. At the wrap, the counter returns to 0 and `blink_on` toggles.
  - Any screen change resets the counter to 0 and sets `blink_on` to 1.
- Pixel datapath:
  - Stage 1 registers `x` = `pixel_index` mod 96 and `y` = `pixel_index` / 96.
  - Indices ≥6144 give `x`=0, `y`=0 and set an invalid flag carried into stage 2.
  - Stage 2 registers `oled_data` from the source selected by `screen`: HOME→`pix_home`, CONTROLS→`pix_ctrl`, GAME→`pix_game`.
  - PAUSE outputs `pix_game` dimmed: R, G and B fields are each shifted right by 1, giving {R>>1, G>>1, B>>1} packed back into RGB565.
  - An invalid index gives 0x0000.

## Timing
- `pixel_index` to `x`/`y`: 1 cycle. `pixel_index` to `oled_data`: 2 cycles.
- The generators are combinational from `x`/`y`.
- `screen` changes in the cycle after `frame_begin` is sampled with a pending request.
- Stage 2 uses the registered `screen`, so the first pixel of the new frame already shows the new screen.
- `game_start` is high for exactly the one cycle in which `screen` first reads 2 coming from HOME. It does not assert on PAUSE→GAME.
- Reset asserted mid-frame or mid-pending: all state returns to reset values asynchronously. Operation resumes on the first clock after deassertion.

## Configuration
- `SCREEN_SEQ_PAUSE_EN` defined: PAUSE state, its transitions and the dimming path are compiled in.
- Without it:
  - `btn_c` in GAME is ignored, and GAME has no exit except reset.
  - `screen` never reads 3.
  - The dimming logic is absent.

## Test plan
- Reset, then `pixel_index`=97 → two cycles later `x`=1, `y`=1 and `oled_data`=`pix_home`; `screen`=0, `blink_on`=1.
- In HOME, pulse `btn_r` mid-frame → `screen` stays 0 until `frame_begin`, then reads 1 the next cycle; a `btn_l` pulse during the pending period is ignored.
- In HOME, pulse `btn_c` and `btn_r` together, then `frame_begin` → `screen`=2 and `game_start` high for exactly 1 cycle.
- With `BLINK_DIV`=4 → `blink_on` toggles every 4 cycles; a screen change restarts the phase with `blink_on`=1.
- With PAUSE compiled in, in GAME with `pix_game`=0xFFFF, pulse `btn_c`, then `frame_begin` → `screen`=3, `oled_data`=0x7BEF. Pulse `btn_l`, then `frame_begin` → HOME.
- `pixel_index`=6144 → `x`=0, `y`=0, `oled_data`=0x0000. Assert `rst_n` low while a request is pending → no screen change after release.
